// File: rtl/miner_chan_regs.sv
// miner_chan_regs: per-channel go/src/dst/len register file on regbus.
// Start pulses, busy tracking, sticky W1C status and a masked level irq.
module miner_chan_regs #(
   parameter int NUM_CHANNELS   = 4,
   parameter int DATA_WIDTH     = 32,
   parameter int ADDR_WIDTH     = 32,
   parameter int DMA_ADDR_WIDTH = 30,
   parameter int LEN_WIDTH      = 32
) (
   input  logic                                     clk,
   input  logic                                     rst_n,
   input  logic                                     reg_addr_valid,
   input  logic                                     reg_write,
   input  logic [ADDR_WIDTH-1:0]                    reg_addr,
   input  logic [DATA_WIDTH-1:0]                    reg_wdata,
   output logic [DATA_WIDTH-1:0]                    reg_rdata,
   output logic                                     reg_ready,
   output logic [NUM_CHANNELS-1:0]                  go,
   output logic [NUM_CHANNELS-1:0]                  busy,
   input  logic [NUM_CHANNELS-1:0]                  done,
   output logic [NUM_CHANNELS*DMA_ADDR_WIDTH-1:0]   src_addr,
   output logic [NUM_CHANNELS*DMA_ADDR_WIDTH-1:0]   dst_addr,
   output logic [NUM_CHANNELS*LEN_WIDTH-1:0]        length,
   output logic                                     irq
);

   typedef enum logic {
      IDLE = 1'b0,
      ACK  = 1'b1
   } state_t;

   state_t state_q, state_d;
   logic   capture;

   logic                  req_wr_q;
   logic [1:0]            req_word_q;
   logic [3:0]            req_ch_q;
   logic [DATA_WIDTH-1:0] req_wdata_q;
   logic [DATA_WIDTH-1:0] rdata_q, rd_mux;
   logic                  wr_en;

   logic [NUM_CHANNELS-1:0] busy_q, go_q, irq_en_q, sts_done_q, err_q;
   logic                    irq_q;

   logic [NUM_CHANNELS-1:0][DMA_ADDR_WIDTH-1:0] src_q, dst_q;
   logic [NUM_CHANNELS-1:0][LEN_WIDTH-1:0]      len_q;

   logic [NUM_CHANNELS-1:0] wr_ctrl, wr_cfg;
   logic [NUM_CHANNELS-1:0] wr_src, wr_dst, wr_len;
   logic [NUM_CHANNELS-1:0] busy_eff, start, err_set, done_set;
   logic [NUM_CHANNELS-1:0] done_clr, err_clr;

   logic unused_bits;
   assign unused_bits = ^{reg_addr[ADDR_WIDTH-1:8], reg_addr[1:0]};

   always_comb begin
      state_d = state_q;
      capture = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (reg_addr_valid) begin
               state_d = ACK;
               capture = 1'b1;
            end
         end
         ACK: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         req_wr_q    <= 1'b0;
         req_word_q  <= '0;
         req_ch_q    <= '0;
         req_wdata_q <= '0;
         rdata_q     <= '0;
      end else begin
         if (capture) begin
            req_wr_q    <= reg_write;
            req_word_q  <= reg_addr[3:2];
            req_ch_q    <= reg_addr[7:4];
            req_wdata_q <= reg_wdata;
         end
         rdata_q <= capture ? rd_mux : '0;
      end
   end

   // Unmatched channel indices fall through and read as zero.
   always_comb begin
      rd_mux = '0;
      for (int i = 0; i < NUM_CHANNELS; i++) begin
         if (reg_addr[7:4] == 4'(i)) begin
            unique case (reg_addr[3:2])
               2'd0: rd_mux[3:0] = {err_q[i], sts_done_q[i],
                                    irq_en_q[i], busy_q[i]};
               2'd1: rd_mux[DMA_ADDR_WIDTH-1:0] = src_q[i];
               2'd2: rd_mux[DMA_ADDR_WIDTH-1:0] = dst_q[i];
               2'd3: rd_mux[LEN_WIDTH-1:0] = len_q[i];
               default: rd_mux = '0;
            endcase
         end
      end
   end

   assign wr_en = (state_q == ACK) && req_wr_q;

   // A done on the same edge retires the run before the write is judged.
   always_comb begin
      for (int i = 0; i < NUM_CHANNELS; i++) begin
         wr_ctrl[i]  = wr_en && (req_ch_q == 4'(i)) && (req_word_q == 2'd0);
         wr_cfg[i]   = wr_en && (req_ch_q == 4'(i)) && (req_word_q != 2'd0);
         busy_eff[i] = busy_q[i] & ~done[i];
         done_set[i] = busy_q[i] & done[i];
         start[i]    = wr_ctrl[i] & req_wdata_q[0] & ~busy_eff[i];
         err_set[i]  = busy_eff[i] &
                       ((wr_ctrl[i] & req_wdata_q[0]) | wr_cfg[i]);
         done_clr[i] = wr_ctrl[i] & req_wdata_q[2];
         err_clr[i]  = wr_ctrl[i] & req_wdata_q[3];
         wr_src[i]   = wr_cfg[i] && !busy_eff[i] && (req_word_q == 2'd1);
         wr_dst[i]   = wr_cfg[i] && !busy_eff[i] && (req_word_q == 2'd2);
         wr_len[i]   = wr_cfg[i] && !busy_eff[i] && (req_word_q == 2'd3);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_q     <= '0;
         go_q       <= '0;
         irq_en_q   <= '0;
         sts_done_q <= '0;
         err_q      <= '0;
         src_q      <= '0;
         dst_q      <= '0;
         len_q      <= '0;
         irq_q      <= 1'b0;
      end else begin
         for (int i = 0; i < NUM_CHANNELS; i++) begin
            go_q[i]       <= start[i];
            busy_q[i]     <= start[i] | busy_eff[i];
            sts_done_q[i] <= done_set[i] | (sts_done_q[i] & ~done_clr[i]);
            err_q[i]      <= err_set[i] | (err_q[i] & ~err_clr[i]);
            if (wr_ctrl[i]) begin
               irq_en_q[i] <= req_wdata_q[1];
            end
            if (wr_src[i]) begin
               src_q[i] <= req_wdata_q[DMA_ADDR_WIDTH-1:0];
            end
            if (wr_dst[i]) begin
               dst_q[i] <= req_wdata_q[DMA_ADDR_WIDTH-1:0];
            end
            if (wr_len[i]) begin
               len_q[i] <= req_wdata_q[LEN_WIDTH-1:0];
            end
         end
         irq_q <= |(sts_done_q & irq_en_q);
      end
   end

   assign reg_ready = (state_q == ACK);
   assign reg_rdata = rdata_q;
   assign go        = go_q;
   assign busy      = busy_q;
   assign irq       = irq_q;
   assign src_addr  = src_q;
   assign dst_addr  = dst_q;
   assign length    = len_q;

endmodule
